addsub27_arb: RTL and testbench
===============================

// Module: addsub27_arb
// PURPOSE
//  Arbiter/sequencer sharing one 27-bit add/sub mantissa datapath between two FPU
//  requesters: port 0 = add/sub mantissa align path, port 1 = div/sqrt iteration.
//  Per-port valid/ready issue, round-robin grant, one-cycle registered result with
//  requester ID and output backpressure. Sits between the requesters and the
//  combinational add/sub unit; result consumers decode res_id.
// PARAMETERS
//  W  27  operand/sum width; carry/borrow is bit W of the (W+1)-bit result
// PORTS
//  clk         in   1  clock; all state updates on rising edge
//  rst_n       in   1  reset, synchronous, active-low
//  req0_valid  in   1  port 0 request
//  req0_ready  out  1  port 0 issue accepted this cycle
//  req0_add    in   1  1 = opa+opb, 0 = opa-opb
//  req0_opa    in   W  operand A
//  req0_opb    in   W  operand B
//  req1_valid / req1_ready / req1_add / req1_opa / req1_opb: same as port 0
//  as_add      out  1  to datapath: op select of granted port
//  as_opa      out  W  to datapath: operand A of granted port
//  as_opb      out  W  to datapath: operand B of granted port
//  as_sum      in   W  from datapath: combinational sum[W-1:0]
//  as_co       in   1  from datapath: carry (add) / borrow (sub), bit W
//  res_valid   out  1  result register holds unconsumed result
//  res_ready   in   1  consumer accepts result this cycle
//  res_sum     out  W  registered sum
//  res_co      out  1  registered carry/borrow
//  res_id      out  1  port that issued the result
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): res_valid=0, res_sum=0, res_co=0, res_id=0, rr_last=1
//   (port 0 wins first tie). Reset mid-operation discards held result; no grant
//   while rst_n=0 (req*_ready=0).
//  Result FSM: EMPTY (res_valid=0) / FULL (res_valid=1).
//   slot_free = EMPTY | (FULL & res_ready).
//   EMPTY: grant -> FULL; else stay.
//   FULL: res_ready & grant -> FULL (new data, back-to-back); res_ready & !grant ->
//   EMPTY; !res_ready -> hold all res_* stable.
//  Grant (combinational, only when slot_free & rst_n):
//   one valid -> grant it; both valid -> grant !rr_last; none -> no grant.
//   rr_last <= granted port on every grant; unchanged otherwise.
//  reqN_ready = grant to N; at most one ready high per cycle. reqN_ready may
//   depend combinationally on reqN_valid and res_ready (no loop: requesters must
//   not drive valid from ready). Requester holds valid/add/opa/opb stable until ready.
//  as_add/as_opa/as_opb = granted port's inputs; all zero when no grant.
//  On grant edge: res_sum<=as_sum, res_co<=as_co, res_id<=port, res_valid<=1.
//  Latency: issue handshake at cycle N -> res_valid at N+1. Throughput 1/cycle
//   while res_ready=1.
//  Arithmetic: add {co,sum}=opa+opb mod 2^(W+1); sub {co,sum}=opa-opb mod 2^(W+1)
//   (co=1 means opa<opb). No saturation; wrap is the required result.
//  Fairness: with both ports continuously valid and res_ready=1, grants alternate
//   0,1,0,1...; no port waits more than 1 grant while the other is served.
//  Stall: res_valid=1 & res_ready=0 -> both ready=0, no as_* activity.
// TESTING
//  T1 reset: rst_n=0 two cycles with both ports valid -> ready0=ready1=0,
//   res_valid=0, res_*=0.
//  T2 single add: port0 add, opa=27'h7FFFFFF, opb=1 -> next cycle res_valid=1,
//   res_sum=0, res_co=1, res_id=0.
//  T3 single sub: port1 sub, opa=5, opb=7 -> res_sum=27'h7FFFFFE, res_co=1, res_id=1;
//   opa=7, opb=5 -> res_sum=2, res_co=0.
//  T4 contention: both valid 6 cycles, res_ready=1 -> res_id sequence 0,1,0,1,0,1,
//   one result per cycle.
//  T5 backpressure: res_ready=0 for 4 cycles with result held -> res_* stable,
//   ready0=ready1=0; release -> pending request granted same cycle as drain.
//  T6 reset mid-op: assert rst_n=0 while FULL with res_ready=0 -> next edge
//   res_valid=0; after release port 0 granted first.

Source files
------------

// File: rtl/addsub27_arb_if.sv
// Bundle of the two requester ports, the shared add/sub datapath link and the
// registered result port. The arbiter connects through `slave`, the surrounding logic through `master`.
interface addsub27_arb_if #(
    parameter int W = 27
);
    logic         req0_valid;
    logic         req0_ready;
    logic         req0_add;
    logic [W-1:0] req0_opa;
    logic [W-1:0] req0_opb;

    logic         req1_valid;
    logic         req1_ready;
    logic         req1_add;
    logic [W-1:0] req1_opa;
    logic [W-1:0] req1_opb;

    logic         as_add;
    logic [W-1:0] as_opa;
    logic [W-1:0] as_opb;
    logic [W-1:0] as_sum;
    logic         as_co;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_co;
    logic         res_id;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_add, req0_opa, req0_opb,
        input  req1_valid, req1_add, req1_opa, req1_opb,
        output req0_ready, req1_ready,
        output as_add, as_opa, as_opb,
        input  as_sum, as_co,
        output res_valid, res_sum, res_co, res_id,
        input  res_ready
    );

    // Requesters, combinational add/sub unit and result consumer.
    modport master (
        output req0_valid, req0_add, req0_opa, req0_opb,
        output req1_valid, req1_add, req1_opa, req1_opb,
        input  req0_ready, req1_ready,
        input  as_add, as_opa, as_opb,
        output as_sum, as_co,
        input  res_valid, res_sum, res_co, res_id,
        output res_ready
    );
endinterface

// File: rtl/addsub27_arb.sv
// Round-robin arbiter sharing one 27-bit add/sub datapath between two FPU requesters,
// with a one-deep registered result slot (EMPTY/FULL) and output backpressure.
module addsub27_arb #(
    parameter int W = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    addsub27_arb_if.slave      bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic         add;
        logic [W-1:0] opa;
        logic [W-1:0] opb;
    } op_t;

    state_e       state_q;
    logic         rr_last_q;
    logic         res_valid_q;
    logic [W-1:0] res_sum_q;
    logic         res_co_q;
    logic         res_id_q;

    logic         slot_free;
    logic         grant;
    logic         gnt_port;
    op_t          op0;
    op_t          op1;
    op_t          op_d;
    logic         rr_last_d;

    assign op0 = '{add: bus.req0_add, opa: bus.req0_opa, opb: bus.req0_opb};
    assign op1 = '{add: bus.req1_add, opa: bus.req1_opa, opb: bus.req1_opb};

    // A new issue is possible when the slot is empty or is being drained this cycle.
    assign slot_free = (state_q == ST_EMPTY) || bus.res_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        grant     = 1'b0;
        gnt_port  = 1'b0;
        op_d      = '0;
        rr_last_d = rr_last_q;
        if (rst_n && slot_free) begin
            unique case ({bus.req1_valid, bus.req0_valid})
                2'b01:   begin grant = 1'b1; gnt_port = 1'b0;       end
                2'b10:   begin grant = 1'b1; gnt_port = 1'b1;       end
                2'b11:   begin grant = 1'b1; gnt_port = !rr_last_q; end
                default: begin grant = 1'b0; gnt_port = 1'b0;       end
            endcase
        end
        if (grant) begin
            op_d      = gnt_port ? op1 : op0;
            rr_last_d = gnt_port;
        end
    end

    assign bus.req0_ready = grant && !gnt_port;
    assign bus.req1_ready = grant &&  gnt_port;

    assign bus.as_add = op_d.add;
    assign bus.as_opa = op_d.opa;
    assign bus.as_opb = op_d.opb;

    // Result slot FSM; outputs are taken straight from registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge and all state uses non-blocking assignment.
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_co_q    <= 1'b0;
            res_id_q    <= 1'b0;
            rr_last_q   <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
            unique case (state_q)
                ST_EMPTY: begin
                    if (grant) begin
                        state_q     <= ST_FULL;
                        res_valid_q <= 1'b1;
                        res_sum_q   <= bus.as_sum;
                        res_co_q    <= bus.as_co;
                        res_id_q    <= gnt_port;
                    end
                end
                ST_FULL: begin
                    if (bus.res_ready) begin
                        if (grant) begin
                            res_sum_q <= bus.as_sum;
                            res_co_q  <= bus.as_co;
                            res_id_q  <= gnt_port;
                        end else begin
                            state_q     <= ST_EMPTY;
                            res_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_co    = res_co_q;
    assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_addsub27_arb.sv
// Directed bench for addsub27_arb: reset, add/sub wrap, round-robin contention,
// result backpressure and reset while a result is held.
module tb_addsub27_arb;

    localparam int W = 27;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    addsub27_arb_if #(.W(W)) bus ();

    addsub27_arb #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Combinational add/sub unit the arbiter drives.
    always_comb begin
        if (bus.as_add) {bus.as_co, bus.as_sum} = {1'b0, bus.as_opa} + {1'b0, bus.as_opb};
        else            {bus.as_co, bus.as_sum} = {1'b0, bus.as_opa} - {1'b0, bus.as_opb};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic add, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req0_valid = v; bus.req0_add = add; bus.req0_opa = a; bus.req0_opb = b;
    endtask

    task automatic set1(input logic v, input logic add, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req1_valid = v; bus.req1_add = add; bus.req1_opa = a; bus.req1_opb = b;
    endtask

    task automatic check_res(input string tag, input logic v, input logic [W-1:0] s,
                             input logic co, input logic id);
        check({tag, ".valid"}, {31'd0, bus.res_valid}, {31'd0, v});
        check({tag, ".sum"},   {5'd0, bus.res_sum},    {5'd0, s});
        check({tag, ".co"},    {31'd0, bus.res_co},    {31'd0, co});
        check({tag, ".id"},    {31'd0, bus.res_id},    {31'd0, id});
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        check({tag, ".ready0"}, {31'd0, bus.req0_ready}, {31'd0, r0});
        check({tag, ".ready1"}, {31'd0, bus.req1_ready}, {31'd0, r1});
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // T1: reset held two cycles with both ports requesting.
        rst_n         = 1'b0;
        bus.res_ready = 1'b1;
        set0(1'b1, 1'b1, 27'd1, 27'd2);
        set1(1'b1, 1'b1, 27'd3, 27'd4);
        tick();
        check_ready("t1_rst_a", 1'b0, 1'b0);
        check_res("t1_rst_a", 1'b0, 27'd0, 1'b0, 1'b0);
        tick();
        check_ready("t1_rst_b", 1'b0, 1'b0);
        check_res("t1_rst_b", 1'b0, 27'd0, 1'b0, 1'b0);

        // T2: port 0 add that carries out of the top bit.
        rst_n = 1'b1;
        set0(1'b1, 1'b1, 27'h7FFFFFF, 27'd1);
        set1(1'b0, 1'b0, 27'd0, 27'd0);
        #1;
        check_ready("t2_issue", 1'b1, 1'b0);
        check("t2_as_opa", {5'd0, bus.as_opa}, 32'h07FF_FFFF);
        check("t2_as_add", {31'd0, bus.as_add}, 32'd1);
        tick();
        set0(1'b0, 1'b0, 27'd0, 27'd0);
        check_res("t2_res", 1'b1, 27'd0, 1'b1, 1'b0);

        // T3: port 1 subtract with borrow, then without, back to back.
        set1(1'b1, 1'b0, 27'd5, 27'd7);
        #1;
        check_ready("t3_issue", 1'b0, 1'b1);
        tick();
        check_res("t3_borrow", 1'b1, 27'h7FFFFFE, 1'b1, 1'b1);
        set1(1'b1, 1'b0, 27'd7, 27'd5);
        tick();
        check_res("t3_noborrow", 1'b1, 27'd2, 1'b0, 1'b1);
        set1(1'b0, 1'b0, 27'd0, 27'd0);
        #1;
        check("t3_idle_opa", {5'd0, bus.as_opa}, 32'd0);
        tick();
        check("t3_drained", {31'd0, bus.res_valid}, 32'd0);

        // T4: both ports continuously valid; last grant went to port 1.
        set0(1'b1, 1'b1, 27'd10, 27'd20);
        set1(1'b1, 1'b0, 27'd100, 27'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i % 2 == 0) check_res($sformatf("t4_g%0d", i), 1'b1, 27'd30, 1'b0, 1'b0);
            else            check_res($sformatf("t4_g%0d", i), 1'b1, 27'd99, 1'b0, 1'b1);
        end
        set0(1'b0, 1'b0, 27'd0, 27'd0);
        set1(1'b0, 1'b0, 27'd0, 27'd0);

        // T5: held result (id 1, 99) under backpressure with port 0 waiting.
        bus.res_ready = 1'b0;
        set0(1'b1, 1'b1, 27'd3, 27'd4);
        #1;
        check_ready("t5_stall", 1'b0, 1'b0);
        check("t5_stall_opa", {5'd0, bus.as_opa}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_res($sformatf("t5_hold%0d", i), 1'b1, 27'd99, 1'b0, 1'b1);
            check_ready($sformatf("t5_hold%0d", i), 1'b0, 1'b0);
        end
        bus.res_ready = 1'b1;
        #1;
        check_ready("t5_release", 1'b1, 1'b0);
        tick();
        set0(1'b0, 1'b0, 27'd0, 27'd0);
        check_res("t5_new", 1'b1, 27'd7, 1'b0, 1'b0);
        tick();
        check("t5_empty", {31'd0, bus.res_valid}, 32'd0);

        // T6: reset while FULL and stalled; last grant before reset is port 0.
        bus.res_ready = 1'b0;
        set0(1'b1, 1'b1, 27'd9, 27'd2);
        tick();
        set0(1'b0, 1'b0, 27'd0, 27'd0);
        check_res("t6_full", 1'b1, 27'd11, 1'b0, 1'b0);
        rst_n = 1'b0;
        set0(1'b1, 1'b1, 27'd1, 27'd1);
        set1(1'b1, 1'b1, 27'd2, 27'd2);
        #1;
        check_ready("t6_in_rst", 1'b0, 1'b0);
        tick();
        check_res("t6_rst", 1'b0, 27'd0, 1'b0, 1'b0);
        rst_n         = 1'b1;
        bus.res_ready = 1'b1;
        #1;
        check_ready("t6_first", 1'b1, 1'b0);
        tick();
        check_res("t6_g0", 1'b1, 27'd2, 1'b0, 1'b0);
        tick();
        check_res("t6_g1", 1'b1, 27'd4, 1'b0, 1'b1);
        set0(1'b0, 1'b0, 27'd0, 27'd0);
        set1(1'b0, 1'b0, 27'd0, 27'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
